// File: rtl/irtifa_sensor_on_isleyici.sv
// Altitude sensor conditioning ahead of the autopilot FSM: two independent
// channels, each with a 4-sample moving average and starvation detection.

module irtifa_kanal #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] data,
  output logic [15:0] avg,
  output logic        timeout,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [15:0]      w0, w1, w2, w3;
  logic [17:0]      sum;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      sum   <= '0;
      cnt   <= '0;
    end else if (clear) begin
      state <= ST_EMPTY;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      sum   <= '0;
      cnt   <= '0;
    end else if (valid) begin
      cnt   <= '0;
      state <= ST_ACTIVE;
      if (state == ST_ACTIVE) begin
        w0  <= data;
        w1  <= w0;
        w2  <= w1;
        w3  <= w2;
        sum <= sum + {2'b00, data} - {2'b00, w3};
      end else begin
        // EMPTY or TIMEOUT: stale history is discarded, window preloaded.
        w0  <= data;
        w1  <= data;
        w2  <= data;
        w3  <= data;
        sum <= {data, 2'b00};
      end
    end else if (cnt != CNT_LIM) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_PRE) state <= ST_TIMEOUT;
    end
  end

  assign avg     = sum[17:2];
  assign timeout = (state == ST_TIMEOUT);
  assign state_o = state;
endmodule

module irtifa_sensor_on_isleyici #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnss_valid_i,
  input  logic [15:0] gnss_data_i,
  input  logic        alt_valid_i,
  input  logic [15:0] alt_data_i,
  input  logic        clear_i,
  output logic [15:0] gnss_o,
  output logic [15:0] altimetre_o,
  output logic        gnss_timeout_o,
  output logic        alt_timeout_o,
  output logic        data_valid_o
);
  // Handshake: valid strobes are accepted unconditionally every cycle they
  // are high (no ready); clear_i wins over a valid in the same cycle.
  localparam logic [1:0] ST_ACTIVE = 2'd1;

  logic [1:0] gnss_state, alt_state;

  irtifa_kanal #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_gnss (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .valid   (gnss_valid_i),
    .data    (gnss_data_i),
    .avg     (gnss_o),
    .timeout (gnss_timeout_o),
    .state_o (gnss_state)
  );

  irtifa_kanal #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_alt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .valid   (alt_valid_i),
    .data    (alt_data_i),
    .avg     (altimetre_o),
    .timeout (alt_timeout_o),
    .state_o (alt_state)
  );

  // Both inputs are state flops, so this changes in step with the averages.
  assign data_valid_o = (gnss_state == ST_ACTIVE) && (alt_state == ST_ACTIVE);
endmodule

// File: doc/irtifa_sensor_on_isleyici.md
Name: irtifa_sensor_on_isleyici

Overview:
- Conditioning stage directly upstream of the autopilot FSM.
- Accepts raw GNSS and altimeter altitude samples, each with its own valid strobe and arriving independently.
- Smooths each channel with a 4-sample moving average and presents stable 16-bit altitudes (gnss_o, altimetre_o) to the FSM's gnss_i/altimetre_i.
- Flags per-channel sample starvation (timeout) and a combined data-valid indication.

Parameters:
- TIMEOUT_CYC, 1000: consecutive cycles without an accepted sample before a channel is declared timed out. Legal range 2..65535.
- CNT_W, 16: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- gnss_valid_i  in  1  GNSS sample strobe, one cycle per sample.
- gnss_data_i  in  16  raw GNSS altitude, unsigned.
- alt_valid_i  in  1  altimeter sample strobe.
- alt_data_i  in  16  raw altimeter altitude, unsigned.
- clear_i  in  1  synchronous flush of both channels.
- gnss_o  out  16  averaged GNSS altitude.
- altimetre_o  out  16  averaged altimeter altitude.
- gnss_timeout_o  out  1  GNSS channel starved.
- alt_timeout_o  out  1  altimeter channel starved.
- data_valid_o  out  1  both channels ACTIVE.

Behaviour:
- Two identical, fully independent channels. Each channel has:
  - a 4-entry sample window w0..w3;
  - an 18-bit running sum;
  - a CNT_W timeout counter;
  - a 2-bit state: EMPTY, ACTIVE, TIMEOUT.
- Reset (async) and clear_i (sync): state EMPTY, window/sum/counter = 0, all outputs 0. clear_i has priority over a valid in the same cycle; that sample is dropped.
- EMPTY + valid: preload all four window entries with the sample, sum = 4*sample, state -> ACTIVE.
- ACTIVE + valid: shift the window (w3 dropped, new sample into w0), sum <= sum + new - w3.
- TIMEOUT + valid: treated as EMPTY (preload, stale history discarded), state -> ACTIVE.
- Averaged output = sum[17:2] (floor division). Registered, so it updates in the cycle after the valid edge (latency 1).
- The 18-bit sum cannot overflow: 4*65535 < 2^18.
- Timeout counter:
  - Cleared to 0 on any accepted sample.
  - Otherwise increments each cycle and saturates at TIMEOUT_CYC.
  - Runs in every state, including EMPTY after reset.
- When the counter reaches TIMEOUT_CYC, state -> TIMEOUT and timeout_o = 1. This is exactly TIMEOUT_CYC cycles after the last accepted sample edge, or after reset release.
- timeout_o stays high until the next accepted sample or clear. It drops in the same cycle the output updates.
- In TIMEOUT the averaged output holds its last value; it is not zeroed.
- data_valid_o = (GNSS state == ACTIVE) && (alt state == ACTIVE), registered with the outputs.
- Valid strobes on both channels in the same cycle are both accepted; no interaction between channels.
- Valid asserted on consecutive cycles: every cycle is a new sample. No back-pressure; the block is always ready.
- Reset mid-operation: immediate return to the reset values above, regardless of state.

Test Plan:
- Preload and averaging (GNSS): reset, then samples 100, 104, 108, 112, 116 on consecutive cycles -> gnss_o = 100, 101, 103, 106, 110, each one cycle after its strobe. data_valid_o stays 0 while the altimeter channel is EMPTY.
- Both channels active: alt samples 50 then 60 alongside the GNSS samples -> altimetre_o 50 then 52; data_valid_o rises the cycle after both channels have one sample.
- Timeout (TIMEOUT_CYC=8): one GNSS sample of 200, then no strobes -> gnss_timeout_o rises 8 cycles after the sample edge, gnss_o holds 200, data_valid_o drops. Next sample 300 -> gnss_o = 300 (preload, not blended), timeout clears.
- Startup starvation: release reset with no strobes, TIMEOUT_CYC=8 -> both timeout_o high at cycle 8, outputs remain 0.
- clear_i with a simultaneous valid (sample 500) while ACTIVE -> outputs 0, states EMPTY, sample ignored. The next sample 40 -> output 40.
- Extremes: four samples of 65535 -> output 65535 with no wrap; then 0, 0, 0, 0 -> 49151, 32767, 16383, 0.
